// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_STEP     = 4;
  localparam logic [7:0]  HALT_OPCODE = 8'hFF;
  localparam int unsigned IR_W        = 32;

endpackage : fetch_pkg

// File: rtl/ir_slot.sv
// Single-entry valid/ready holding register between fetch and decode.
// A load always wins; otherwise a flush or an accepted handshake empties it.
module ir_slot
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            ready_i,
  input  logic [IR_W-1:0] data_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            valid_o,
  output logic [IR_W-1:0] data_o,
  output logic [PC_W-1:0] pc_o
);

  logic            valid_q;
  logic [IR_W-1:0] data_q;
  logic [PC_W-1:0] pc_q;

  // Slot register: capture on load, drop on flush or on a consumed entry.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is written with <= so every register samples pre-edge values; = here would create order-dependent simulation.
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end else if (flush_i || ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule : ir_slot

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: program counter, START/FETCH(/HALT) FSM,
// redirect handling and the accepted-instruction counter.
// Optional feature: define FETCH_HALT_DETECT_EN to stop fetching on opcode 8'hFF.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] mem_addr,
  input  logic [7:0]      mem_b1,
  input  logic [7:0]      mem_b2,
  input  logic [7:0]      mem_b3,
  input  logic [7:0]      mem_b4,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [IR_W-1:0] ir_data,
  output logic [PC_W-1:0] ir_pc,
  output logic            halted,
  output logic [7:0]      instr_count
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      count_q, count_d;
  logic            slot_free;
  logic            fetch_en;
  logic            handshake;
  logic            unused_redirect_lsbs;

  // Redirect targets are word aligned; the low two bits carry no meaning.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign slot_free = !ir_valid || ir_ready;
  assign handshake = ir_valid && ir_ready;
  assign fetch_en  = (state_q == ST_FETCH) && slot_free && !redirect_valid;
  assign mem_addr  = pc_q;

`ifdef FETCH_HALT_DETECT_EN
  logic halted_q, halted_d;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // Next-state logic: redirect first, then START->FETCH, then PC advance.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    pc_d    = pc_q;
`ifdef FETCH_HALT_DETECT_EN
    halted_d = halted_q;
`endif
    if (redirect_valid) begin
      pc_d    = {redirect_pc[PC_W-1:2], 2'b00};
      state_d = ST_FETCH;
`ifdef FETCH_HALT_DETECT_EN
      halted_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_START: state_d = ST_FETCH;
        ST_FETCH: begin
          if (slot_free) begin
`ifdef FETCH_HALT_DETECT_EN
            if (mem_b1 == HALT_OPCODE) begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end else begin
              pc_d = pc_q + PC_W'(PC_STEP);
            end
`else
            pc_d = pc_q + PC_W'(PC_STEP);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Handshakes complete regardless of redirect, so the counter only sees the handshake.
  always_comb begin
    count_d = count_q;
    if (handshake) count_d = count_q + 8'd1;
  end

  // PC, FSM and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_START;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  // Halt flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end
`endif

  assign instr_count = count_q;

  ir_slot #(.PC_W(PC_W)) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (fetch_en),
    .flush_i (redirect_valid),
    .ready_i (ir_ready),
    .data_i  ({mem_b1, mem_b2, mem_b3, mem_b4}),
    .pc_i    (pc_q),
    .valid_o (ir_valid),
    .data_o  (ir_data),
    .pc_o    (ir_pc)
  );

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural byte memory, a scoreboard of
// expected (pc, instruction) pairs popped on every handshake, plus cycle checks.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned PC_W = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PC_W-1:0] mem_addr;
  logic [7:0]      mem_b1, mem_b2, mem_b3, mem_b4;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            ir_valid;
  logic            ir_ready;
  logic [31:0]     ir_data;
  logic [PC_W-1:0] ir_pc;
  logic            halted;
  logic [7:0]      instr_count;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     data;
  } exp_t;

  logic [7:0] mem [64];
  exp_t       sb [$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         hs_cnt   = 0;

  fetch_unit #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_b1         (mem_b1),
    .mem_b2         (mem_b2),
    .mem_b3         (mem_b3),
    .mem_b4         (mem_b4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_data        (ir_data),
    .ir_pc          (ir_pc),
    .halted         (halted),
    .instr_count    (instr_count)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory.
  assign mem_b1 = mem[{mem_addr[5:2], 2'b00}];
  assign mem_b2 = mem[{mem_addr[5:2], 2'b01}];
  assign mem_b3 = mem[{mem_addr[5:2], 2'b10}];
  assign mem_b4 = mem[{mem_addr[5:2], 2'b11}];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] word_at(input logic [PC_W-1:0] a);
    return {mem[a], mem[a + 6'd1], mem[a + 6'd2], mem[a + 6'd3]};
  endfunction

  task automatic expect_from(input logic [PC_W-1:0] start, input int n);
    logic [PC_W-1:0] p;
    exp_t e;
    sb.delete();
    p = start;
    for (int i = 0; i < n; i++) begin
      e.pc   = p;
      e.data = word_at(p);
      sb.push_back(e);
      p = p + 6'd4;
    end
  endtask

  // One clock: score a handshake happening on this edge, then advance to edge+1.
  task automatic tick();
    exp_t e;
    if (ir_valid && ir_ready) begin
      if (sb.size() == 0) begin
        check("sb_empty", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        check("hs_pc", 64'(ir_pc), 64'(e.pc));
        check("hs_data", 64'(ir_data), 64'(e.data));
      end
      hs_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 1);
    rst_n          = 1'b0;
    ir_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    check("rst_valid", 64'(ir_valid), 64'd0);
    check("rst_data", 64'(ir_data), 64'd0);
    check("rst_irpc", 64'(ir_pc), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_count", 64'(instr_count), 64'd0);

    // First fetch: START edge, then fetch edge.
    rst_n = 1'b1;
    expect_from(6'd0, 4);
    tick();
    check("start_valid", 64'(ir_valid), 64'd0);
    check("start_addr", 64'(mem_addr), 64'd0);
    tick();
    check("f0_valid", 64'(ir_valid), 64'd1);
    check("f0_data", 64'(ir_data), 64'h01020304);
    check("f0_pc", 64'(ir_pc), 64'd0);
    check("f0_addr", 64'(mem_addr), 64'd4);
    tick();
    check("f1_pc", 64'(ir_pc), 64'd4);
    check("f1_count", 64'(instr_count), 64'd1);

    // Back-pressure: slot and PC hold for five cycles.
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 64'(ir_valid), 64'd1);
      check("stall_pc", 64'(ir_pc), 64'd4);
      check("stall_data", 64'(ir_data), 64'h05060708);
      check("stall_addr", 64'(mem_addr), 64'd8);
      check("stall_count", 64'(instr_count), 64'd1);
    end
    ir_ready = 1'b1;
    tick();
    check("release_count", 64'(instr_count), 64'd2);
    check("release_pc", 64'(ir_pc), 64'd8);

    // Redirect to 56 and stream through the 60 -> 0 wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 6'd56;
    tick();
    redirect_valid = 1'b0;
    expect_from(6'd56, 6);
    check("r56_addr", 64'(mem_addr), 64'd56);
    check("r56_valid", 64'(ir_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wrap_valid", 64'(ir_valid), 64'd1);
      check("wrap_pc", 64'(ir_pc), 64'((56 + 4 * i) % 64));
    end
    check("wrap_count", 64'(instr_count), 64'(8'(hs_cnt)));

    // Redirect to an unaligned target mid-stream.
    redirect_valid = 1'b1;
    redirect_pc    = 6'd23;
    tick();
    redirect_valid = 1'b0;
    expect_from(6'd20, 4);
    check("r23_addr", 64'(mem_addr), 64'd20);
    check("r23_valid", 64'(ir_valid), 64'd0);
    check("r23_count", 64'(instr_count), 64'(8'(hs_cnt)));
    tick();
    check("r23_tvalid", 64'(ir_valid), 64'd1);
    check("r23_tpc", 64'(ir_pc), 64'd20);
    tick();

    // Opcode FF at address 8.
    mem[8] = 8'hFF;
    redirect_valid = 1'b1;
    redirect_pc    = 6'd0;
    tick();
    redirect_valid = 1'b0;
    expect_from(6'd0, 4);
    repeat (3) tick();
    check("ff_pc", 64'(ir_pc), 64'd8);
    check("ff_data", 64'(ir_data), 64'hFF0A0B0C);
`ifdef FETCH_HALT_DETECT_EN
    check("ff_halted", 64'(halted), 64'd1);
    check("ff_addr", 64'(mem_addr), 64'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_valid", 64'(ir_valid), 64'd0);
      check("halt_addr", 64'(mem_addr), 64'd8);
      check("halt_flag", 64'(halted), 64'd1);
    end
`else
    check("ff_halted", 64'(halted), 64'd0);
    check("ff_addr", 64'(mem_addr), 64'd12);
    tick();
    check("ff_next_pc", 64'(ir_pc), 64'd12);
`endif

    // Resume from 0 and run long enough to wrap the counter.
    mem[8] = 8'h09;
    redirect_valid = 1'b1;
    redirect_pc    = 6'd0;
    tick();
    redirect_valid = 1'b0;
    check("resume_halted", 64'(halted), 64'd0);
    check("resume_addr", 64'(mem_addr), 64'd0);
    expect_from(6'd0, 300);
    tick();
    check("resume_valid", 64'(ir_valid), 64'd1);
    check("resume_pc", 64'(ir_pc), 64'd0);
    repeat (260) tick();
    check("cnt_wrap", 64'(instr_count), 64'(8'(hs_cnt)));
    check("cnt_wrapped", 64'(hs_cnt > 255), 64'd1);

    // Asynchronous reset while the slot is stalled and full.
    ir_ready = 1'b0;
    tick();
    check("pre_rst_valid", 64'(ir_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(ir_valid), 64'd0);
    check("arst_addr", 64'(mem_addr), 64'd0);
    check("arst_count", 64'(instr_count), 64'd0);
    check("arst_halted", 64'(halted), 64'd0);
    hs_cnt = 0;
    sb.delete();
    #1;
    rst_n    = 1'b1;
    ir_ready = 1'b1;
    expect_from(6'd0, 4);
    tick();
    check("rerun_start", 64'(ir_valid), 64'd0);
    tick();
    check("rerun_valid", 64'(ir_valid), 64'd1);
    check("rerun_pc", 64'(ir_pc), 64'd0);
    tick();
    check("rerun_count", 64'(instr_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_unit
